// File: rtl/booth_seq_mul_if.sv
// Start/done handshake and operand/result bundle for the sequential Booth multiplier.
// The control sequencer is the master; the multiplier is the slave.
interface booth_seq_mul_if #(
    parameter int WIDTH = 32
);
    logic                   Start;
    logic [WIDTH-1:0]       Multiplicand;
    logic [WIDTH-1:0]       Multiplier;
    logic                   Busy;
    logic                   Done;
    logic [2*WIDTH-1:0]     Product;

    modport master (
        output Start, Multiplicand, Multiplier,
        input  Busy, Done, Product
    );

    modport slave (
        input  Start, Multiplicand, Multiplier,
        output Busy, Done, Product
    );
endinterface

// File: rtl/booth_seq_mul.sv
// Signed WIDTHxWIDTH multiplier, radix-4 Booth, one bit-pair per clock.
// Latency WIDTH/2 cycles from the Start edge to Done; one product per WIDTH/2+1 cycles.
// Start is ignored while Busy; Done is a one-cycle pulse, Product holds until the next completion.
module booth_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic            Clock,
    input  logic            Clear,
    booth_seq_mul_if.slave  bus
);
    localparam int AW   = WIDTH + 2;
    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER) + 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_seq_mul: WIDTH must be even and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [AW-1:0]      m_reg;
    logic [AW-1:0]      a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q_1;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_reg;

    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      a_shf;
    logic [WIDTH-1:0]   q_shf;
    logic               accept;
    logic               last_iter;

    assign accept    = bus.Start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == CW'(ITER - 1));

    // Booth recoding of the current bit pair plus the bit shifted out last time.
    always_comb begin
        addend = '0;
        case ({q_reg[1:0], q_1})
            3'b001, 3'b010: addend = m_reg;
            3'b011:         addend = m_reg << 1;
            3'b100:         addend = -(m_reg << 1);
            3'b101, 3'b110: addend = -m_reg;
            default:        addend = '0;
        endcase
    end

    // Two guard bits in A keep A +/- 2M exact, so the arithmetic shift never loses sign.
    assign sum   = a_reg + addend;
    assign a_shf = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_shf = {sum[1:0], q_reg[WIDTH-1:2]};

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = bus.Start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            q_1         <= 1'b0;
            cnt         <= '0;
            product_reg <= '0;
        end else if (accept) begin
            m_reg <= {{2{bus.Multiplicand[WIDTH-1]}}, bus.Multiplicand};
            a_reg <= '0;
            q_reg <= bus.Multiplier;
            q_1   <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_shf;
            q_reg <= q_shf;
            q_1   <= q_reg[1];
            cnt   <= cnt + 1'b1;
            // Only the final iteration publishes, so Product never shows a partial sum.
            if (last_iter) begin
                product_reg <= {a_shf[WIDTH-1:0], q_shf};
            end
        end
    end

    assign bus.Busy    = (state == RUN);
    assign bus.Done    = (state == DONE);
    assign bus.Product = product_reg;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed-vector bench for booth_seq_mul: latency, Busy/Done timing, products, ignored Start, Clear, back-to-back.
module tb_booth_seq_mul;
    localparam int W = 32;

    logic Clock;
    logic Clear;

    booth_seq_mul_if #(.WIDTH(W)) bus ();

    booth_seq_mul #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present operands with Start for one edge, then scramble operands after capture.
    task automatic launch(input logic [W-1:0] m, input logic [W-1:0] q);
        @(negedge Clock);
        bus.Start        = 1'b1;
        bus.Multiplicand = m;
        bus.Multiplier   = q;
        @(posedge Clock);
        #1;
        bus.Start        = 1'b0;
        bus.Multiplicand = $urandom;
        bus.Multiplier   = $urandom;
    endtask

    // Count cycles after the Start edge until Done; optionally pulse a stray Start mid-run.
    task automatic wait_done(input int pulse_at, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        @(negedge Clock);
        while (!bus.Done && lat < 40) begin
            if (bus.Busy) busy_cnt++;
            if (lat == pulse_at) begin
                bus.Start        = 1'b1;
                bus.Multiplicand = 32'd9;
                bus.Multiplier   = 32'd9;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge Clock);
            lat++;
        end
        bus.Start = 1'b0;
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                           input logic [63:0] exp, input int pulse_at);
        int lat;
        int busy_cnt;
        launch(m, q);
        wait_done(pulse_at, lat, busy_cnt);
        check({tag, " latency"}, 64'(lat), 64'd16);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd16);
        check({tag, " busy_at_done"}, 64'(bus.Busy), 64'd0);
        check({tag, " product"}, bus.Product, exp);
        @(negedge Clock);
        check({tag, " done_falls"}, 64'(bus.Done), 64'd0);
        check({tag, " product_holds"}, bus.Product, exp);
    endtask

    initial begin
        int gap;
        int pulses;

        bus.Start        = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;
        Clear            = 1'b1;
        repeat (3) @(negedge Clock);
        check("reset busy", 64'(bus.Busy), 64'd0);
        check("reset done", 64'(bus.Done), 64'd0);
        check("reset product", bus.Product, 64'd0);
        Clear = 1'b0;
        @(negedge Clock);

        run_mul("small",     32'h0000_0022, 32'h0000_0024, 64'h0000_0000_0000_04C8, -1);
        run_mul("neg1x1",    32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, -1);
        run_mul("minxmin",   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
        run_mul("maxxmin",   32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, -1);
        run_mul("zero",      32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, -1);
        run_mul("maxxmax",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, -1);
        run_mul("neg1xneg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, -1);
        run_mul("ignored",   32'd5,         32'd7,         64'h0000_0000_0000_0023, 4);

        // Asynchronous Clear mid-run discards the operation and zeroes outputs at once.
        launch(32'd3, 32'd3);
        repeat (8) @(negedge Clock);
        #2 Clear = 1'b1;
        #1;
        check("clear busy", 64'(bus.Busy), 64'd0);
        check("clear done", 64'(bus.Done), 64'd0);
        check("clear product", bus.Product, 64'd0);
        @(negedge Clock);
        Clear  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (bus.Done || bus.Busy) pulses++;
        end
        check("clear no_activity", 64'(pulses), 64'd0);

        run_mul("after_clear", 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, -1);

        // Start held high: Done every 17 cycles, Product stable in between.
        @(negedge Clock);
        bus.Start        = 1'b1;
        bus.Multiplicand = 32'd2;
        bus.Multiplier   = 32'd3;
        for (int p = 0; p < 3; p++) begin
            gap = 0;
            do begin
                @(negedge Clock);
                gap++;
                if (p > 0 && gap == 8) check($sformatf("b2b stable %0d", p), bus.Product, 64'd6);
            end while (!bus.Done && gap < 40);
            check($sformatf("b2b gap %0d", p), 64'(gap), 64'd17);
            check($sformatf("b2b product %0d", p), bus.Product, 64'd6);
        end
        @(negedge Clock);
        check("b2b done_pulse", 64'(bus.Done), 64'd0);
        check("b2b rerun", 64'(bus.Busy), 64'd1);
        bus.Start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
